// File: rtl/sysbus_mem_responder.sv
// Memory responder on the system bus: 8-beat line reads and writes with fixed read latency.
// Define SYSBUS_CRITICAL_WORD_FIRST_EN to start read beats at the addressed word and wrap within the line.
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_BYTES      = 65536,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int WW    = AW - 3;
    localparam int WORDS = MEM_BYTES / 8;
    localparam int LW    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, LAT, RESP, WDATA} state_t;

    state_t                    state_q;
    logic [BUS_DATA_WIDTH-1:0] mem_q [WORDS];
    logic [WW-1:0]             base_q;
    logic [2:0]                beat_q;
    logic [LW-1:0]             lat_q;
    logic [BUS_TAG_WIDTH-1:0]  tag_q;
    logic                      bus_respcyc_q;
    logic [BUS_DATA_WIDTH-1:0] bus_resp_q;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag_q;

    logic          dev_hit;
    logic [WW-1:0] rd_base;
    logic [WW-1:0] wr_base;
    logic [WW-1:0] next_word;
    logic [WW-1:0] wr_word;
    logic          unused_bits;

    assign dev_hit = (bus_reqtag[11:8] == 4'b0001);
    assign wr_base = {bus_req[AW-1:6], 3'b000};
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
    assign rd_base = bus_req[AW-1:3];
`else
    assign rd_base = {bus_req[AW-1:6], 3'b000};
`endif
    // base_q low bits hold the starting word; beats wrap inside the line
    assign next_word   = {base_q[WW-1:3], base_q[2:0] + beat_q + 3'd1};
    assign wr_word     = {base_q[WW-1:3], beat_q};
    assign unused_bits = ^{bus_req[BUS_DATA_WIDTH-1:AW], bus_req[5:0]};

    assign bus_reqack  = !reset && bus_reqcyc &&
                         (((state_q == IDLE) && dev_hit) || (state_q == WDATA));
    assign bus_respcyc = bus_respcyc_q;
    assign bus_resp    = bus_resp_q;
    assign bus_resptag = bus_resptag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            base_q        <= '0;
            beat_q        <= '0;
            lat_q         <= '0;
            tag_q         <= '0;
            bus_respcyc_q <= 1'b0;
            bus_resp_q    <= '0;
            bus_resptag_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_reqcyc && dev_hit) begin
                        tag_q  <= bus_reqtag;
                        beat_q <= '0;
                        if (bus_reqtag[12]) begin
                            base_q <= rd_base;
                            if (READ_LATENCY == 1) begin
                                state_q       <= RESP;
                                bus_respcyc_q <= 1'b1;
                                bus_resp_q    <= mem_q[rd_base];
                                bus_resptag_q <= bus_reqtag;
                            end else begin
                                state_q <= LAT;
                                lat_q   <= LW'(READ_LATENCY - 2);
                            end
                        end else begin
                            base_q  <= wr_base;
                            state_q <= WDATA;
                        end
                    end
                end
                LAT: begin
                    if (lat_q == '0) begin
                        state_q       <= RESP;
                        bus_respcyc_q <= 1'b1;
                        bus_resp_q    <= mem_q[base_q];
                        bus_resptag_q <= tag_q;
                    end else begin
                        lat_q <= lat_q - LW'(1);
                    end
                end
                RESP: begin
                    if (bus_respack) begin
                        if (beat_q == 3'd7) begin
                            state_q       <= IDLE;
                            beat_q        <= '0;
                            bus_respcyc_q <= 1'b0;
                            bus_resp_q    <= '0;
                            bus_resptag_q <= '0;
                        end else begin
                            beat_q     <= beat_q + 3'd1;
                            bus_resp_q <= mem_q[next_word];
                        end
                    end
                end
                WDATA: begin
                    if (bus_reqcyc) begin
                        beat_q <= beat_q + 3'd1;
                        if (beat_q == 3'd7) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is never reset so a reset mid-write keeps the beats already written
    always_ff @(posedge clk) begin
        if (!reset && (state_q == WDATA) && bus_reqcyc) begin
            mem_q[wr_word] <= bus_req;
        end
    end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Randomized self-checking bench for sysbus_mem_responder against a line-level memory model.
module tb_sysbus_mem_responder;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int MB = 65536;
    localparam int RL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;

    always #5 clk = ~clk;

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH(DW),
        .BUS_TAG_WIDTH (TW),
        .MEM_BYTES     (MB),
        .READ_LATENCY  (RL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_reqcyc (bus_reqcyc),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_reqack (bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp   (bus_resp),
        .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] got [8];
    int got_first, got_last, got_n, got_after, got_acked, tag_errs, hold_errs;

    function automatic int line_word(input logic [63:0] a);
        return int'((a % MB) / 64) * 8;
    endfunction

    function automatic logic [DW-1:0] exp_beat(input logic [63:0] a, input int i);
        int start;
        int w;
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
        start = int'((a / 8) % 8);
`else
        start = 0;
`endif
        w = line_word(a) + (start + i) % 8;
        if (model_mem.exists(w)) return model_mem[w];
        return '0;
    endfunction

    task automatic idle_inputs();
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [TW-1:0] tag,
                            input logic [DW-1:0] d [8], input int gap_at, input int gap_len,
                            input int abort_after, output int req_acked,
                            output int data_acks, output int resp_seen);
        int base;
        base = line_word(addr);
        data_acks = 0;
        resp_seen = 0;
        bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag; bus_respack = 1'b0;
        @(negedge clk);
        req_acked = int'(bus_reqack);
        if (bus_respcyc) resp_seen++;
        @(posedge clk); #1;
        for (int b = 0; b < 8; b++) begin
            if (b == abort_after) begin
                bus_reqcyc = 1'b0;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                break;
            end
            if (b == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    bus_reqcyc = 1'b0; bus_req = '0;
                    @(negedge clk);
                    if (bus_reqack) data_acks++;
                    if (bus_respcyc) resp_seen++;
                    @(posedge clk); #1;
                end
            end
            bus_reqcyc = 1'b1; bus_req = d[b];
            @(negedge clk);
            if (bus_reqack) data_acks++;
            if (bus_respcyc) resp_seen++;
            model_mem[base + b] = d[b];
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [TW-1:0] tag,
                           input int stall_beat, input int stall_len, input int reset_at);
        int c;
        int stalls;
        logic [DW-1:0] held;
        tag_errs = 0; hold_errs = 0; got_n = 0; got_first = -1; got_last = -1;
        got_after = 1; stalls = 0; held = '0;
        for (int i = 0; i < 8; i++) got[i] = '0;
        bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag; bus_respack = 1'b1;
        @(negedge clk);
        got_acked = int'(bus_reqack);
        @(posedge clk); #1;
        bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
        c = 1;
        while (got_n < 8 && c < 64) begin
            bus_respack = !(got_n == stall_beat && stalls < stall_len);
            @(negedge clk);
            if (bus_respcyc) begin
                if (got_n == reset_at) begin
                    reset = 1'b1;
                    @(posedge clk); #1;
                    reset = 1'b0;
                    bus_respack = 1'b0;
                    @(negedge clk);
                    got_after = int'(bus_respcyc);
                    @(posedge clk); #1;
                    idle_inputs();
                    return;
                end
                if (got_first < 0) got_first = c;
                if (bus_resptag !== tag) tag_errs++;
                if (got_n == stall_beat) begin
                    if (stalls == 0) held = bus_resp;
                    else if (bus_resp !== held) hold_errs++;
                end
                if (bus_respack) begin
                    got[got_n] = bus_resp;
                    got_last = c;
                    got_n++;
                end else begin
                    stalls++;
                end
            end
            @(posedge clk); #1;
            c++;
        end
        bus_respack = 1'b0;
        @(negedge clk);
        got_after = int'(bus_respcyc);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_reqcyc = 1'b1; bus_req = 64'h1000; bus_reqtag = 13'h1105; bus_respack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus_reqack !== 1'b0) begin miscompares++; $display("FAIL reset_reqack got %b want 0", bus_reqack); end
        vectors++; if (bus_respcyc !== 1'b0) begin miscompares++; $display("FAIL reset_respcyc got %b want 0", bus_respcyc); end
        vectors++; if (bus_resp !== '0) begin miscompares++; $display("FAIL reset_resp got %h want 0", bus_resp); end
        vectors++; if (bus_resptag !== '0) begin miscompares++; $display("FAIL reset_resptag got %h want 0", bus_resptag); end
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_preload();
        logic [DW-1:0] d [8];
        int ra, da, rs;
        for (int k = 0; k < 8; k++) d[k] = DW'(32'hA0 + k);
        do_write(64'h1000, 13'h0105, d, -1, 0, -1, ra, da, rs);
        vectors++; if (ra !== 1) begin miscompares++; $display("FAIL preload_req_ack got %0d want 1", ra); end
        vectors++; if (da !== 8) begin miscompares++; $display("FAIL preload_data_acks got %0d want 8", da); end
        vectors++; if (rs !== 0) begin miscompares++; $display("FAIL preload_no_resp got %0d want 0", rs); end
    endtask

    task automatic test_basic_read();
        do_read(64'h1000, 13'h1105, -1, 0, -1);
        vectors++; if (got_acked !== 1) begin miscompares++; $display("FAIL basic_ack got %0d want 1", got_acked); end
        vectors++; if (got_first !== RL) begin miscompares++; $display("FAIL basic_first_beat got %0d want %0d", got_first, RL); end
        vectors++; if (got_last !== RL + 7) begin miscompares++; $display("FAIL basic_last_beat got %0d want %0d", got_last, RL + 7); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got[i] !== DW'(32'hA0 + i)) begin miscompares++; $display("FAIL basic_beat%0d got %h want %h", i, got[i], 32'hA0 + i); end
        end
        vectors++; if (tag_errs !== 0) begin miscompares++; $display("FAIL basic_tag errors %0d want 0", tag_errs); end
        vectors++; if (got_after !== 0) begin miscompares++; $display("FAIL basic_respcyc_drop got %0d want 0", got_after); end
    endtask

    task automatic test_critical_word();
        logic [DW-1:0] first;
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
        first = DW'(32'hA5);
`else
        first = DW'(32'hA0);
`endif
        do_read(64'h1028, 13'h1106, -1, 0, -1);
        vectors++; if (got[0] !== first) begin miscompares++; $display("FAIL cwf_first got %h want %h", got[0], first); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got[i] !== exp_beat(64'h1028, i)) begin miscompares++; $display("FAIL cwf_beat%0d got %h want %h", i, got[i], exp_beat(64'h1028, i)); end
        end
    endtask

    task automatic test_stall();
        do_read(64'h1000, 13'h1107, 2, 3, -1);
        vectors++; if (hold_errs !== 0) begin miscompares++; $display("FAIL stall_hold errors %0d want 0", hold_errs); end
        vectors++; if (got_last !== RL + 10) begin miscompares++; $display("FAIL stall_last_beat got %0d want %0d", got_last, RL + 10); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got[i] !== exp_beat(64'h1000, i)) begin miscompares++; $display("FAIL stall_beat%0d got %h want %h", i, got[i], exp_beat(64'h1000, i)); end
        end
    endtask

    task automatic test_write_gap();
        logic [DW-1:0] d [8];
        int ra, da, rs;
        for (int k = 0; k < 8; k++) d[k] = DW'(8'h11 * (k + 1));
        do_write(64'h2000, 13'h0107, d, 4, 2, -1, ra, da, rs);
        vectors++; if (ra !== 1) begin miscompares++; $display("FAIL wgap_req_ack got %0d want 1", ra); end
        vectors++; if (da !== 8) begin miscompares++; $display("FAIL wgap_data_acks got %0d want 8", da); end
        vectors++; if (rs !== 0) begin miscompares++; $display("FAIL wgap_no_resp got %0d want 0", rs); end
        do_read(64'h2000, 13'h1108, -1, 0, -1);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got[i] !== exp_beat(64'h2000, i)) begin miscompares++; $display("FAIL wgap_beat%0d got %h want %h", i, got[i], exp_beat(64'h2000, i)); end
        end
    endtask

    task automatic test_mmio();
        int acks = 0, resps = 0;
        for (int i = 0; i < 6; i++) begin
            bus_reqcyc = 1'b1; bus_req = {$urandom, $urandom};
            bus_reqtag = (i % 2 == 0) ? 13'h1305 : 13'h0305;
            @(negedge clk);
            if (bus_reqack) acks++;
            if (bus_respcyc) resps++;
            @(posedge clk); #1;
        end
        idle_inputs();
        vectors++; if (acks !== 0) begin miscompares++; $display("FAIL mmio_acks got %0d want 0", acks); end
        vectors++; if (resps !== 0) begin miscompares++; $display("FAIL mmio_resp got %0d want 0", resps); end
    endtask

    task automatic test_busy_read();
        int c, n1, n2, ack2, last1;
        bus_reqcyc = 1'b1; bus_req = 64'h1000; bus_reqtag = 13'h1101; bus_respack = 1'b1;
        @(negedge clk);
        vectors++; if (bus_reqack !== 1'b1) begin miscompares++; $display("FAIL busy_first_ack got %b want 1", bus_reqack); end
        @(posedge clk); #1;
        bus_req = 64'h2000; bus_reqtag = 13'h1102;
        c = 1; n1 = 0; n2 = 0; ack2 = -1; last1 = -1;
        while (n2 < 8 && c < 100) begin
            @(negedge clk);
            if (bus_reqack && ack2 < 0) ack2 = c;
            if (bus_respcyc) begin
                vectors++;
                if (n1 < 8) begin
                    if (bus_resp !== exp_beat(64'h1000, n1) || bus_resptag !== 13'h1101) begin
                        miscompares++; $display("FAIL busy_a_beat%0d got %h/%h want %h/1101", n1, bus_resp, bus_resptag, exp_beat(64'h1000, n1));
                    end
                    n1++; last1 = c;
                end else begin
                    if (bus_resp !== exp_beat(64'h2000, n2) || bus_resptag !== 13'h1102) begin
                        miscompares++; $display("FAIL busy_b_beat%0d got %h/%h want %h/1102", n2, bus_resp, bus_resptag, exp_beat(64'h2000, n2));
                    end
                    n2++;
                end
            end
            @(posedge clk); #1;
            if (ack2 >= 0) begin bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; end
            c++;
        end
        idle_inputs();
        @(posedge clk); #1;
        vectors++; if (!(ack2 > last1 && ack2 <= last1 + 2)) begin miscompares++; $display("FAIL busy_second_ack got cycle %0d want after %0d", ack2, last1); end
        vectors++; if (n2 !== 8) begin miscompares++; $display("FAIL busy_second_beats got %0d want 8", n2); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d [8];
        int ra, da, rs;
        do_read(64'h2000, 13'h1109, -1, 0, 3);
        vectors++; if (got_after !== 0) begin miscompares++; $display("FAIL rstmid_respcyc got %0d want 0", got_after); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (got[i] !== exp_beat(64'h2000, i)) begin miscompares++; $display("FAIL rstmid_beat%0d got %h want %h", i, got[i], exp_beat(64'h2000, i)); end
        end
        do_read(64'h2008, 13'h110A, -1, 0, -1);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got[i] !== exp_beat(64'h2008, i)) begin miscompares++; $display("FAIL rstmid_fresh%0d got %h want %h", i, got[i], exp_beat(64'h2008, i)); end
        end
        for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
        do_write(64'h3000, 13'h010B, d, -1, 0, -1, ra, da, rs);
        for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
        do_write(64'h3010, 13'h010C, d, -1, 0, 3, ra, da, rs);
        vectors++; if (da !== 3) begin miscompares++; $display("FAIL rstwr_acks got %0d want 3", da); end
        do_read(64'h3000, 13'h110D, -1, 0, -1);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got[i] !== exp_beat(64'h3000, i)) begin miscompares++; $display("FAIL rstwr_beat%0d got %h want %h", i, got[i], exp_beat(64'h3000, i)); end
        end
    endtask

    task automatic test_random();
        logic [63:0] lines [4];
        logic [DW-1:0] d [8];
        logic [63:0] a;
        logic [TW-1:0] t;
        int ra, da, rs, sb, sl;
        lines[0] = 64'h4000; lines[1] = 64'h4040; lines[2] = 64'h8000; lines[3] = 64'hFFC0;
        for (int op = 0; op < 24; op++) begin
            a = lines[op < 4 ? op : $urandom_range(3)] | 64'($urandom_range(63));
            a = a | ({32'($urandom), 32'h0} & 64'hFFFF_FFFF_FFFF_0000);
            if (op < 4 || $urandom_range(2) == 0) begin
                for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
                t = {5'b00001, 8'($urandom)};
                do_write(a, t, d, $urandom_range(7), $urandom_range(2), -1, ra, da, rs);
                vectors++; if (ra !== 1 || da !== 8 || rs !== 0) begin miscompares++; $display("FAIL rand_write%0d got ack %0d beats %0d resp %0d want 1/8/0", op, ra, da, rs); end
            end else begin
                t = {5'b10001, 8'($urandom)};
                sb = $urandom_range(7); sl = $urandom_range(3);
                do_read(a, t, sb, sl, -1);
                vectors++; if (got_first !== RL || got_last !== RL + 7 + sl) begin miscompares++; $display("FAIL rand_timing%0d got %0d/%0d want %0d/%0d", op, got_first, got_last, RL, RL + 7 + sl); end
                vectors++; if (tag_errs !== 0 || hold_errs !== 0 || got_after !== 0) begin miscompares++; $display("FAIL rand_proto%0d got tag %0d hold %0d after %0d want 0/0/0", op, tag_errs, hold_errs, got_after); end
                for (int i = 0; i < 8; i++) begin
                    vectors++;
                    if (got[i] !== exp_beat(a, i)) begin miscompares++; $display("FAIL rand_read%0d_beat%0d got %h want %h", op, i, got[i], exp_beat(a, i)); end
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_preload();
        test_basic_read();
        test_critical_word();
        test_stall();
        test_write_gap();
        test_mmio();
        test_busy_read();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 SHALL provide the following parameters (name, default, meaning):
- BUS_DATA_WIDTH, 64, bus data width.
- BUS_TAG_WIDTH, 13, bus tag width.
- MEM_BYTES, 65536, backing store size; power of two, multiple of 64.
- READ_LATENCY, 4, cycles from request acceptance to first read beat; minimum 1.

REQ-002 SHALL provide the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- bus_reqcyc, in, 1, initiator request/write-beat valid.
- bus_req, in, 64, request address, or write data in the data phase.
- bus_reqtag, in, 13, bit 12 = 1 read / 0 write; bits 11:8 device (4'b0001 = memory); bits 7:0 transaction id.
- bus_reqack, out, 1, request or write beat accepted this cycle.
- bus_respcyc, out, 1, read beat valid.
- bus_resp, out, 64, read beat data.
- bus_resptag, out, 13, tag of the request being answered.
- bus_respack, in, 1, initiator consumed the current read beat.

Function
REQ-003 SHALL hold MEM_BYTES of storage as 64-bit words; word index = bus_req[log2(MEM_BYTES)-1:3]; higher address bits ignored (modulo wrap).
REQ-004 SHALL implement states IDLE, LAT, RESP and WDATA.
REQ-005 In IDLE, bus_reqack SHALL equal bus_reqcyc AND (bus_reqtag[11:8] == 4'b0001); the address and tag are latched in that cycle T.
REQ-006 SHALL never ack tags with a non-memory device field; it stays in IDLE and drives no response.
REQ-007 On an accepted read, SHALL go to LAT and assert bus_respcyc first at cycle T+READ_LATENCY; READ_LATENCY=1 goes directly to RESP.
REQ-008 In RESP, bus_respcyc SHALL stay high; bus_resp/bus_resptag hold until bus_respack is sampled high. The next beat is presented the following cycle.
REQ-009 A read SHALL return exactly 8 beats (one 64-byte line). After the 8th bus_respack, bus_respcyc drops the next cycle and the state returns to IDLE.
REQ-010 bus_resptag SHALL equal the latched request tag for all 8 beats; it is 0 when bus_respcyc is low.
REQ-011 On an accepted write, SHALL go to WDATA. bus_reqack = bus_reqcyc; each acked cycle writes bus_req to line word 0..7 in order, and the state returns to IDLE after the 8th beat.
REQ-012 Write line base SHALL be bus_req with bits 5:0 cleared; no response beats are generated for writes.
REQ-013 Requests arriving in LAT, RESP or WDATA (other than write beats) SHALL NOT be acked. They are accepted once IDLE is re-entered, at the earliest the cycle after returning.
REQ-014 bus_respack while bus_respcyc is low SHALL be ignored.
REQ-015 A read following a write to the same line SHALL return the new data (no stale-data hazard).

Reset
REQ-016 While reset is high, SHALL force state IDLE, beat and latency counters 0, bus_reqack 0, bus_respcyc 0, bus_resp 0 and bus_resptag 0.
REQ-017 Reset mid-transaction SHALL abort it without completing remaining beats. Memory contents are retained, and partially written lines keep the beats already written.

Configuration
REQ-018 Macro SYSBUS_CRITICAL_WORD_FIRST_EN SHALL control read beat ordering.
- Defined: read beats start at word w = bus_req[5:3] and wrap modulo 8 (w, w+1, ..., w+7 mod 8).
- Undefined: read beats are always words 0..7 of the line, ignoring bus_req[5:0].
- Writes are unaffected in both cases.

Verification
REQ-019 Preload word k of line 0x1000 with 0xA0+k. Read 0x1000, tag 0x1105, respack always high. Required: bus_reqack at T; beats 0xA0..0xA7 at cycles T+4..T+11; bus_resptag 0x1105 on every beat; bus_respcyc low at T+12.
REQ-020 Same preload, read address 0x1028.
- With the macro: beat order 0xA5, 0xA6, 0xA7, 0xA0, ..., 0xA4.
- Without the macro: 0xA0..0xA7.
REQ-021 Respack stall: hold bus_respack low for 3 cycles on beat 2. Required: beat 2 data held for those 3 cycles plus the ack cycle, with no beat lost or duplicated.
REQ-022 Write to 0x2000 with tag 0x0107 and data 0x11..0x88, with a 2-cycle reqcyc gap before beat 4; then read 0x2000. Required: 8 write acks, no response during the write, and the read returns 0x11..0x88.
REQ-023 Mixed requests:
- Tag 0x1305 (MMIO device): never acked.
- Read issued during RESP of another read: not acked until after that read's 8th beat.
- Reset asserted at beat 3: next cycle bus_respcyc=0; a fresh read then returns the correct data.
